// File: rtl/mem_pkg.sv
// Shared data-memory types: responder FSM states, the request record used by
// core-side initiators, and the address legality check.
package mem_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic                    we;
        logic [31:0]             addr;
        logic [31:0]             wdata;
        logic [WORD_BYTES-1:0]   wstrb;
    } dmem_req_t;

    // Misaligned, or beyond the end of a depth_words-word array.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth_words);
        logic [32:0] limit;
        limit = 33'(depth_words) * 33'(WORD_BYTES);
        return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-strobed synchronous write and synchronous read.
// Read data only changes on an enabled read, so it stays stable while a response waits.
module dmem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic                           en_i,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [31:0]                    wdata_i,
    input  logic [WORD_BYTES-1:0]          wstrb_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < int'(WORD_BYTES); b++) begin
                    if (wstrb_i[b]) begin
                        mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one outstanding request, programmable wait,
// strobed word access into dmem_array, response held until accepted.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned      AW       = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    logic             err_q, err_d;
    logic             load_q, load_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic             acc_bad;
    logic             ram_en;
    logic [31:0]      ram_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        load_d  = load_q;
        acc_bad = addr_bad(req_q.addr, DEPTH_WORDS);
        ram_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d = '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
                    if (LATENCY == 0) begin
                        state_d = ACCESS;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACCESS: begin
                ram_en  = !acc_bad;
                err_d   = acc_bad;
                load_d  = !acc_bad && !req_q.we;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered copies of the next state.
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            err_q       <= 1'b0;
            load_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            err_q       <= err_d;
            load_q      <= load_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk_i  (clk),
        .en_i   (ram_en),
        .we_i   (req_q.we),
        .idx_i  (req_q.addr[AW+1:2]),
        .wdata_i(req_q.wdata),
        .wstrb_i(req_q.wstrb),
        .rdata_o(ram_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    // Stores and errors return zero; load data sits in the RAM read register.
    assign rsp_rdata = (rsp_valid_q && load_q) ? ram_rdata : '0;
    assign rsp_err   = rsp_valid_q && err_q;

endmodule
